// File: rtl/mult_div_ctrl_if.sv
// Handshake and operand/result bundle between ctrl_unit and the
// iterative multiply/divide sequencer.
interface mult_div_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic              op;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic              busy;
    logic              done;
    logic              hi_lo_w;
    logic [DATA_W-1:0] hi_out;
    logic [DATA_W-1:0] lo_out;
    logic              div_zero;

    modport master (
        output start, op, src_a, src_b,
        input  busy, done, hi_lo_w, hi_out, lo_out, div_zero
    );

    modport slave (
        input  start, op, src_a, src_b,
        output busy, done, hi_lo_w, hi_out, lo_out, div_zero
    );
endinterface

// File: rtl/mult_div_ctrl.sv
// Iterative signed multiply / restoring divide sequencer feeding HI/LO.
// Works on operand magnitudes for 32 steps, then applies sign correction.
module mult_div_ctrl #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 5
) (
    input  logic           clk,
    input  logic           reset,
    mult_div_ctrl_if.slave bus
);
    localparam int W2 = 2 * DATA_W;

    typedef enum logic [1:0] {IDLE, RUN, FIN, ERR} state_t;

    state_t state;
    state_t state_nx;

    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] mag_a;
    logic [DATA_W-1:0] mag_b;
    logic [DATA_W-1:0] rem;
    logic [W2-1:0]     acc;
    logic              op_q;
    logic              neg_res;
    logic              neg_rem;
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;

    logic              b_zero;
    logic              accept;
    logic              last;
    logic [DATA_W-1:0] abs_a;
    logic [DATA_W-1:0] abs_b;
    logic [DATA_W:0]   msum;
    logic [DATA_W:0]   shl;
    logic              ge;
    logic [DATA_W-1:0] rem_nx;
    logic [W2-1:0]     acc_mul;
    logic [W2-1:0]     acc_div;
    logic [W2-1:0]     prod;
    logic [DATA_W-1:0] quo_fix;
    logic [DATA_W-1:0] rem_fix;

    assign b_zero = (bus.src_b == '0);
    assign accept = (state == IDLE) && bus.start && !(bus.op && b_zero);
    assign last   = (cnt == '0);

    assign abs_a = bus.src_a[DATA_W-1] ? -bus.src_a : bus.src_a;
    assign abs_b = bus.src_b[DATA_W-1] ? -bus.src_b : bus.src_b;

    // Mult step: add multiplicand into the upper half, shift right by one.
    assign msum    = {1'b0, acc[W2-1:DATA_W]}
                   + {1'b0, (acc[0] ? mag_a : {DATA_W{1'b0}})};
    assign acc_mul = {msum, acc[DATA_W-1:1]};

    // Div step: 33-bit partial remainder, dividend bits shift out of acc.
    assign shl     = {rem, acc[DATA_W-1]};
    assign ge      = (shl >= {1'b0, mag_b});
    assign rem_nx  = ge ? DATA_W'(shl - {1'b0, mag_b})
                        : shl[DATA_W-1:0];
    assign acc_div = {acc[W2-1:DATA_W], acc[DATA_W-2:0], ge};

    assign prod    = neg_res ? -acc_mul : acc_mul;
    assign quo_fix = neg_res ? -acc_div[DATA_W-1:0]
                             : acc_div[DATA_W-1:0];
    assign rem_fix = neg_rem ? -rem_nx : rem_nx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        bus.hi_lo_w  = 1'b0;
        bus.div_zero = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nx = (bus.op && b_zero) ? ERR : RUN;
                end
            end
            RUN: begin
                bus.busy = 1'b1;
                if (last) begin
                    state_nx = FIN;
                end
            end
            FIN: begin
                bus.busy    = 1'b1;
                bus.done    = 1'b1;
                bus.hi_lo_w = 1'b1;
                state_nx    = IDLE;
            end
            ERR: begin
                bus.done     = 1'b1;
                bus.div_zero = 1'b1;
                state_nx     = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            mag_a   <= '0;
            mag_b   <= '0;
            rem     <= '0;
            acc     <= '0;
            op_q    <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else if (accept) begin
            cnt     <= CNT_W'(DATA_W - 1);
            mag_a   <= abs_a;
            mag_b   <= abs_b;
            rem     <= '0;
            acc     <= bus.op ? {{DATA_W{1'b0}}, abs_a}
                              : {{DATA_W{1'b0}}, abs_b};
            op_q    <= bus.op;
            neg_res <= bus.src_a[DATA_W-1] ^ bus.src_b[DATA_W-1];
            neg_rem <= bus.src_a[DATA_W-1];
        end else if (state == RUN) begin
            acc <= op_q ? acc_div : acc_mul;
            rem <= rem_nx;
            if (!last) begin
                cnt <= cnt - 1'b1;
            end else if (op_q) begin
                hi_q <= rem_fix;
                lo_q <= quo_fix;
            end else begin
                hi_q <= prod[W2-1:DATA_W];
                lo_q <= prod[DATA_W-1:0];
            end
        end
    end

    assign bus.hi_out = hi_q;
    assign bus.lo_out = lo_q;
endmodule

// File: tb/tb_mult_div_ctrl.sv
// Directed vector bench for the multiply/divide sequencer.
// Table-driven ops plus divide-by-zero and mid-op reset sequences.
module tb_mult_div_ctrl;
    logic clk;
    logic reset;

    mult_div_ctrl_if #(.DATA_W(32)) bus ();

    mult_div_ctrl #(.DATA_W(32), .CNT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        bit          noise;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    int checks = 0;
    int fails  = 0;
    int viol   = 0;
    logic prev_done = 1'b0;
    logic prev_w    = 1'b0;
    logic prev_z    = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobes must never stay high two samples in a row.
    always @(negedge clk) begin
        if ((bus.done && prev_done) || (bus.hi_lo_w && prev_w)
            || (bus.div_zero && prev_z)) begin
            viol++;
        end
        prev_done = bus.done;
        prev_w    = bus.hi_lo_w;
        prev_z    = bus.div_zero;
    end

    task automatic chk(input string n, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", n, got, exp);
        end
    endtask

    task automatic run_op(input logic o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh,
                          input logic [31:0] el, input bit noise);
        int cyc;
        bus.start = 1'b1;
        bus.op    = o;
        bus.src_a = a;
        bus.src_b = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = 1'($urandom);
        bus.src_a = $urandom;
        bus.src_b = $urandom;
        cyc = 0;
        while (!bus.done && cyc < 40) begin
            bus.start = noise && (cyc == 5 || cyc == 20);
            @(negedge clk);
            cyc++;
        end
        bus.start = noise;
        chk("latency", 64'(cyc), 64'd32);
        chk("fin_w", 64'(bus.hi_lo_w), 64'd1);
        chk("fin_dz", 64'(bus.div_zero), 64'd0);
        chk("fin_busy", 64'(bus.busy), 64'd1);
        chk("hi", 64'(bus.hi_out), 64'(eh));
        chk("lo", 64'(bus.lo_out), 64'(el));
        @(negedge clk);
        bus.start = 1'b0;
        chk("post_done", 64'(bus.done), 64'd0);
        chk("post_w", 64'(bus.hi_lo_w), 64'd0);
        chk("post_busy", 64'(bus.busy), 64'd0);
        chk("hold", {bus.hi_out, bus.lo_out}, {eh, el});
        if (noise) begin
            @(negedge clk);
            chk("fin_start_ign", 64'({bus.busy, bus.done}), 64'd0);
        end
    endtask

    initial begin
        int stray;
        vecs[0]  = '{1'b0, 32'h7,        32'hFFFFFFFD,
                     32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[1]  = '{1'b0, 32'h80000000, 32'h80000000,
                     32'h40000000, 32'h00000000, 1'b0};
        vecs[2]  = '{1'b1, 32'hFFFFFFF9, 32'h2,
                     32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3]  = '{1'b1, 32'd100,      32'd7,
                     32'd2,        32'd14,       1'b0};
        vecs[4]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF,
                     32'h0,        32'h80000000, 1'b1};
        vecs[5]  = '{1'b0, 32'h12345678, 32'h10,
                     32'h1,        32'h23456780, 1'b0};
        vecs[6]  = '{1'b1, 32'd7,        32'hFFFFFFFE,
                     32'h1,        32'hFFFFFFFD, 1'b0};
        vecs[7]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                     32'h0,        32'h1,        1'b0};
        vecs[8]  = '{1'b0, 32'hFFFFFFFF, 32'h1,
                     32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
        vecs[9]  = '{1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9,
                     32'hFFFFFFFE, 32'hE,        1'b1};
        vecs[10] = '{1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF,
                     32'h3FFFFFFF, 32'h00000001, 1'b0};
        vecs[11] = '{1'b1, 32'd5,        32'd10,
                     32'd5,        32'd0,        1'b0};

        reset     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.src_a = '0;
        bus.src_b = '0;
        repeat (2) @(negedge clk);
        chk("rst_ctl", 64'({bus.busy, bus.done, bus.hi_lo_w,
                            bus.div_zero}), 64'd0);
        chk("rst_data", {bus.hi_out, bus.lo_out}, 64'd0);
        reset = 1'b1;
        bus.op    = 1'b1;
        bus.src_b = '0;
        @(negedge clk);
        chk("idle_nostart", 64'({bus.busy, bus.done}), 64'd0);

        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].hi, vecs[i].lo, vecs[i].noise);
        end

        bus.start = 1'b1;
        bus.op    = 1'b1;
        bus.src_a = 32'd123;
        bus.src_b = 32'd0;
        @(negedge clk);
        bus.start = 1'b0;
        chk("dz_flag", 64'({bus.done, bus.div_zero, bus.hi_lo_w,
                            bus.busy}), 64'b1100);
        chk("dz_hold", {bus.hi_out, bus.lo_out},
            {vecs[NV-1].hi, vecs[NV-1].lo});
        @(negedge clk);
        chk("dz_after", 64'({bus.done, bus.div_zero, bus.busy}), 64'd0);

        bus.start = 1'b1;
        bus.op    = 1'b0;
        bus.src_a = 32'd5;
        bus.src_b = 32'd6;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("arst_ctl", 64'({bus.busy, bus.done, bus.hi_lo_w,
                             bus.div_zero}), 64'd0);
        chk("arst_data", {bus.hi_out, bus.lo_out}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        stray = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done || bus.hi_lo_w || bus.busy) stray++;
        end
        chk("abort_quiet", 64'(stray), 64'd0);
        run_op(1'b0, 32'd7, 32'hFFFFFFFD,
               32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);

        chk("pulse_width", 64'(viol), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/mult_div_ctrl.md
Name: mult_div_ctrl

Overview:
Sequencer for the iterative signed multiply/divide unit that feeds the HI/LO registers of the multicycle CPU. ctrl_unit issues a one-cycle start with an opcode and the two operands (A/B register outputs). The block runs a 32-step shift/add (mult) or shift/subtract (div) sequence, then presents HI/LO results with a one-cycle write strobe and a done pulse. Divide-by-zero is flagged back to ctrl_unit as ErroDiv.

Parameters:
DATA_W, 32, operand/result width; the only supported value is 32.
CNT_W, 5, iteration counter width; must satisfy 2^CNT_W = DATA_W.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset.
start  input  1  request pulse from ctrl_unit; sampled only in IDLE.
op  input  1  0 = mult (signed), 1 = div (signed).
src_a  input  DATA_W  multiplicand / dividend (A register).
src_b  input  DATA_W  multiplier / divisor (B register).
busy  output  1  high in RUN and FIN.
done  output  1  one-cycle completion pulse.
hi_lo_w  output  1  one-cycle write strobe for the HI and LO registers.
hi_out  output  DATA_W  mult: product[63:32]; div: remainder.
lo_out  output  DATA_W  mult: product[31:0]; div: quotient.
div_zero  output  1  one-cycle ErroDiv pulse.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy, done, hi_lo_w, div_zero = 0; hi_out, lo_out = 0; counter = 0. This applies mid-operation: an aborted op produces no strobe after reset deasserts.
- States: IDLE, RUN, FIN, ERR.
- IDLE, start=1, and (op=0 or src_b!=0): at edge E0, latch |src_a|, |src_b|, result-sign and remainder-sign (sign of src_a), set counter=31, go to RUN.
- IDLE, start=1, op=1, src_b=0: at E0 go to ERR. ERR lasts one cycle: div_zero=1, done=1, hi_lo_w=0, hi_out/lo_out hold previous values. Then go to IDLE.
- RUN: one iteration per edge on magnitudes.
  - Mult: 64-bit accumulator, add-and-shift.
  - Div: restoring, with a 33-bit partial remainder.
  - Counter decrements each edge. The edge at which counter==0 (E32) performs the last iteration and registers the sign-corrected results into hi_out/lo_out, then goes to FIN.
- Sign correction:
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
  - All arithmetic is mod 2^32 per half.
- FIN: one cycle with done=1 and hi_lo_w=1; hi_out/lo_out are valid and stable. Then go to IDLE. Latency is start sampled at E0 to done high in the cycle after E32, i.e. 32 cycles.
- hi_out/lo_out hold their values until the next completed op.
- start in RUN/FIN/ERR is ignored and not queued. start in the same cycle as FIN is ignored.
- Operand inputs are don't-care after E0.
- op=1, src_a=0x80000000, src_b=0xFFFFFFFF: lo_out=0x80000000, hi_out=0, no flag (wraps).
- op and unused inputs are ignored in IDLE without start.
- done, hi_lo_w and div_zero are never high for more than one consecutive cycle.

Test Plan:
- Mult 7 x -3: start, src_a=7, src_b=0xFFFFFFFD -> done after 32 cycles, hi_out=0xFFFFFFFF, lo_out=0xFFFFFFEB, hi_lo_w pulse 1 cycle.
- Mult 0x80000000 x 0x80000000 -> hi_out=0x40000000, lo_out=0x00000000. Back-to-back start in the cycle after FIN is accepted.
- Div -7/2 (0xFFFFFFF9, 2) -> lo_out=0xFFFFFFFD, hi_out=0xFFFFFFFF. Div 100/7 -> lo_out=14, hi_out=2.
- Div by zero (src_b=0) -> next cycle div_zero=1 and done=1, hi_lo_w=0, hi_out/lo_out unchanged from the prior op, busy=0.
- Div 0x80000000/0xFFFFFFFF -> lo_out=0x80000000, hi_out=0, div_zero=0. Start pulses during RUN are ignored: exactly one done.
- Assert reset low at iteration 10 of a mult -> all outputs 0 immediately. After release no done or hi_lo_w appears, and a new start completes normally.
